// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: register map, CTRL bit positions and channel FSM states shared by the timer bank.
// Latency/backpressure: n/a (constants and pure helper functions only).
// The optional PWM output is controlled by TIMER_PWM_EN in the modules that import this package.
package timer_bank_pkg;

    localparam logic [7:0] CH_STRIDE    = 8'h10;
    localparam logic [3:0] OFF_CTRL     = 4'h0;
    localparam logic [3:0] OFF_PRESCALE = 4'h4;
    localparam logic [3:0] OFF_COUNT    = 4'h8;
    localparam logic [3:0] OFF_COMPARE  = 4'hC;
    localparam logic [7:0] ADDR_STATUS  = 8'hF0;
    localparam logic [7:0] ADDR_ID      = 8'hF4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IE     = 2;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] m;
        m = be_mask(be);
        return (old_val & ~m) | (new_val & m);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one prescaled up-counter with compare match and IDLE/RUN control; pwm output only with TIMER_PWM_EN.
// Latency: writes and ticks act at the clock edge; match is a combinational pulse in the tick cycle.
// Backpressure: none; a COUNT or CTRL write always wins over a coincident tick.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int PRE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic        wr_prescale,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] data_in,
    input  logic [3:0]  byte_select,
    output logic [31:0] ctrl_rd,
    output logic [31:0] prescale_rd,
    output logic [31:0] count_rd,
    output logic [31:0] compare_rd,
    output logic        ie,
    output logic        match
`ifdef TIMER_PWM_EN
    ,
    output logic        pwm
`endif
);

    ch_state_e            state;
    ch_state_e            state_nxt;
    logic                 reload;
    logic                 en;
    logic [PRE_WIDTH-1:0] prescale;
    logic [PRE_WIDTH-1:0] pre;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] compare;
    logic [2:0]           ctrl_new;
    logic                 tick;
    logic                 tick_ok;
    logic                 at_compare;
    logic                 start;

    assign en         = (state == CH_RUN);
    assign ctrl_new   = 3'(merge_be(ctrl_rd, data_in, byte_select));
    assign tick       = en && (pre == prescale);
    // A same-cycle COUNT/CTRL write swallows the tick and any match it would cause.
    assign tick_ok    = tick && !wr_ctrl && !wr_count;
    assign at_compare = (count == compare);
    assign match      = tick_ok && at_compare;
    assign start      = (state == CH_IDLE) && (state_nxt == CH_RUN);

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[CTRL_EN]     = en;
        ctrl_rd[CTRL_RELOAD] = reload;
        ctrl_rd[CTRL_IE]     = ie;
    end

    assign prescale_rd = 32'(prescale);
    assign count_rd    = 32'(count);
    assign compare_rd  = 32'(compare);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CH_IDLE: begin
                if (wr_ctrl && ctrl_new[CTRL_EN]) begin
                    state_nxt = CH_RUN;
                end
            end
            CH_RUN: begin
                if (wr_ctrl && !ctrl_new[CTRL_EN]) begin
                    state_nxt = CH_IDLE;
                end else if (match && !reload) begin
                    state_nxt = CH_IDLE;
                end
            end
            default: state_nxt = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if ((state_nxt == CH_IDLE) || start || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie       <= 1'b0;
            reload   <= 1'b0;
            prescale <= '0;
            compare  <= '0;
            count    <= '0;
        end else begin
            if (wr_ctrl) begin
                ie     <= ctrl_new[CTRL_IE];
                reload <= ctrl_new[CTRL_RELOAD];
            end
            if (wr_prescale) begin
                prescale <= PRE_WIDTH'(merge_be(prescale_rd, data_in, byte_select));
            end
            if (wr_compare) begin
                compare <= CNT_WIDTH'(merge_be(compare_rd, data_in, byte_select));
            end
            if (wr_count) begin
                count <= CNT_WIDTH'(merge_be(count_rd, data_in, byte_select));
            end else if (tick_ok) begin
                if (at_compare) begin
                    if (reload) begin
                        count <= '0;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

`ifdef TIMER_PWM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm <= 1'b0;
        end else begin
            pwm <= en && (count < compare);
        end
    end
`endif

endmodule

// File: rtl/timer_bank.sv
// timer_bank: memory-mapped bank of NUM_CH prescaled compare timers with W1C status and irq; pwm_out with TIMER_PWM_EN.
// Latency: writes act at the clock edge; data_out is registered, valid the cycle after ren and held until the next ren.
// Backpressure: none; every bus access completes in one cycle.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32,
    parameter int PRE_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ren,
    input  logic              wen,
    input  logic [7:0]        address,
    input  logic [31:0]       data_in,
    input  logic [3:0]        byte_select,
    output logic [31:0]       data_out,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
`ifdef TIMER_PWM_EN
    ,
    output logic [NUM_CH-1:0] pwm_out
`endif
);

    logic [3:0]        ch_sel;
    logic [3:0]        reg_off;
    logic              status_hit;
    logic              id_hit;
    logic              unused_addr;
    logic [31:0]       rd_data;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ch_ie;
    logic [NUM_CH-1:0] ch_match;
    logic [31:0]       ch_ctrl     [NUM_CH];
    logic [31:0]       ch_prescale [NUM_CH];
    logic [31:0]       ch_count    [NUM_CH];
    logic [31:0]       ch_compare  [NUM_CH];

    assign ch_sel      = address[7:4];
    assign reg_off     = {address[3:2], 2'b00};
    assign status_hit  = (address[7:2] == ADDR_STATUS[7:2]);
    assign id_hit      = (address[7:2] == ADDR_ID[7:2]);
    assign unused_addr = ^address[1:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wen && (ch_sel == 4'(i));

        timer_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .PRE_WIDTH (PRE_WIDTH)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .wr_ctrl     (sel && (reg_off == OFF_CTRL)),
            .wr_prescale (sel && (reg_off == OFF_PRESCALE)),
            .wr_count    (sel && (reg_off == OFF_COUNT)),
            .wr_compare  (sel && (reg_off == OFF_COMPARE)),
            .data_in     (data_in),
            .byte_select (byte_select),
            .ctrl_rd     (ch_ctrl[i]),
            .prescale_rd (ch_prescale[i]),
            .count_rd    (ch_count[i]),
            .compare_rd  (ch_compare[i]),
            .ie          (ch_ie[i]),
            .match       (ch_match[i])
`ifdef TIMER_PWM_EN
            ,
            .pwm         (pwm_out[i])
`endif
        );
    end

    // A match in the same cycle as its W1C keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (wen && status_hit) begin
            pending <= (pending & ~NUM_CH'(data_in & be_mask(byte_select))) | ch_match;
        end else begin
            pending <= pending | ch_match;
        end
    end

    always_comb begin
        rd_data = '0;
        if (status_hit) begin
            rd_data = 32'(pending);
        end else if (id_hit) begin
            rd_data = {16'h0000, 8'(CNT_WIDTH), 8'(NUM_CH)};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == 4'(i)) begin
                    case (reg_off)
                        OFF_CTRL:     rd_data = ch_ctrl[i];
                        OFF_PRESCALE: rd_data = ch_prescale[i];
                        OFF_COUNT:    rd_data = ch_count[i];
                        OFF_COMPARE:  rd_data = ch_compare[i];
                        default:      rd_data = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (ren) begin
            data_out <= rd_data;
        end
    end

    assign irq     = pending & ch_ie;
    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed scenarios plus randomized channel configs checked against closed-form timing.
// pwm_out is only connected and exercised when TIMER_PWM_EN is defined.
`timescale 1ns/1ps
module tb_timer_bank;
    import timer_bank_pkg::*;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ren;
    logic              wen;
    logic [7:0]        address;
    logic [31:0]       data_in;
    logic [3:0]        byte_select;
    logic [31:0]       data_out;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;
`ifdef TIMER_PWM_EN
    logic [NUM_CH-1:0] pwm_out;
`endif

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int last_wr;

    int r_p  [NUM_CH];
    int r_c  [NUM_CH];
    int r_c0 [NUM_CH];
    int r_e0 [NUM_CH];
    int r_rl [NUM_CH];
    int r_ie [NUM_CH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(32), .PRE_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .ren         (ren),
        .wen         (wen),
        .address     (address),
        .data_in     (data_in),
        .byte_select (byte_select),
        .data_out    (data_out),
        .irq         (irq),
        .irq_any     (irq_any)
`ifdef TIMER_PWM_EN
        ,
        .pwm_out     (pwm_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ra(input int ch, input logic [3:0] off);
        return 8'(ch * int'(CH_STRIDE) + int'(off));
    endfunction

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; data_in = d; byte_select = be; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0; byte_select = 4'h0;
        last_wr = cyc;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        address = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        d = data_out;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_irq(input int b, input int bound, output int edge_no);
        edge_no = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (irq[b]) begin
                edge_no = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Closed-form model: ticks land every P+1 edges after enable, first match after C-C0+1 ticks.
    function automatic int ticks_at(input int ch, input int n);
        if (n < r_e0[ch]) return 0;
        return (n - r_e0[ch]) / (r_p[ch] + 1);
    endfunction

    function automatic int k_first(input int ch);
        return r_c[ch] - r_c0[ch] + 1;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_pending(input int n);
        logic [NUM_CH-1:0] v;
        for (int ch = 0; ch < NUM_CH; ch++) v[ch] = (ticks_at(ch, n) >= k_first(ch));
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] ie_mask();
        logic [NUM_CH-1:0] v;
        for (int ch = 0; ch < NUM_CH; ch++) v[ch] = (r_ie[ch] != 0);
        return v;
    endfunction

    function automatic logic [31:0] exp_count(input int ch, input int n);
        int t;
        int k;
        t = ticks_at(ch, n);
        k = k_first(ch);
        if (t < k) return 32'(r_c0[ch] + t);
        if (r_rl[ch] != 0) return 32'((t - k) % (r_c[ch] + 1));
        return 32'(r_c[ch]);
    endfunction

    function automatic logic [31:0] exp_ctrl(input int ch, input int n);
        if (r_rl[ch] == 0 && ticks_at(ch, n) >= k_first(ch)) return 32'(r_ie[ch] * 4);
        return 32'(r_ie[ch] * 4 + r_rl[ch] * 2 + 1);
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int e0;
        int rise;
        int hi;
        logic [NUM_CH-1:0] ep;

        reset = 1'b1; ren = 1'b0; wen = 1'b0;
        address = 8'h00; data_in = 32'h0; byte_select = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_dout", data_out, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_irq_any", 32'(irq_any), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-run with an active interrupt and non-zero data_out.
        bus_write(ra(0, OFF_PRESCALE), 32'd0, 4'hF);
        bus_write(ra(0, OFF_COMPARE), 32'd1, 4'hF);
        bus_write(ra(0, OFF_CTRL), 32'd7, 4'hF);
        repeat (4) @(negedge clk);
        check("t1_irq_before", 32'(irq_any), 32'h1);
        bus_read(ADDR_ID, rd);
        check("id", rd, 32'h0000_2004);
        reset = 1'b1;
        #1;
        check("t1_dout", data_out, 32'h0);
        check("t1_irq", 32'(irq), 32'h0);
        check("t1_irq_any", 32'(irq_any), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_read(ra(0, OFF_CTRL), rd);    check("t1_ctrl0", rd, 32'h0);
        bus_read(ra(0, OFF_COUNT), rd);   check("t1_count0", rd, 32'h0);
        bus_read(ADDR_STATUS, rd);        check("t1_status", rd, 32'h0);
        bus_read(8'h40, rd);              check("unmapped_40", rd, 32'h0);
        bus_read(8'hF8, rd);              check("unmapped_f8", rd, 32'h0);

        // Byte-masked writes.
        bus_write(ra(0, OFF_PRESCALE), 32'hAABB_CCDD, 4'b0010);
        bus_write(ra(0, OFF_PRESCALE), 32'h1122_3344, 4'b0001);
        bus_read(ra(0, OFF_PRESCALE), rd); check("be_prescale", rd, 32'h0000_CC44);
        bus_write(ra(0, OFF_COMPARE), 32'hAABB_CCDD, 4'b1100);
        bus_read(ra(0, OFF_COMPARE), rd);  check("be_compare", rd, 32'hAABB_0000);

        // Periodic ch0: 24-clock period, W1C clears, W1C on the match edge loses.
        bus_write(ra(0, OFF_PRESCALE), 32'd3, 4'hF);
        bus_write(ra(0, OFF_COMPARE), 32'd5, 4'hF);
        bus_write(ra(0, OFF_CTRL), 32'd7, 4'hF);
        e0 = last_wr;
        wait_irq(0, 60, rise);
        check("t2_first_rise", 32'(rise - e0), 32'd24);
        check("t2_irq_any", 32'(irq_any), 32'h1);
        bus_write(ADDR_STATUS, 32'h1, 4'hF);
        check("t2_w1c_clear", 32'(irq[0]), 32'h0);
        wait_irq(0, 60, rise);
        check("t2_second_rise", 32'(rise - e0), 32'd48);
        bus_write(ADDR_STATUS, 32'h1, 4'hF);
        check("t2_w1c_clear2", 32'(irq_any), 32'h0);
        wait_until(e0 + 71);
        bus_write(ADDR_STATUS, 32'h1, 4'hF);
        check("t5_w1c_on_match", 32'(irq[0]), 32'h1);
        bus_write(ra(0, OFF_CTRL), 32'd0, 4'hF);
        bus_write(ADDR_STATUS, 32'hF, 4'hF);

        // One-shot ch1.
        bus_write(ra(1, OFF_PRESCALE), 32'd0, 4'hF);
        bus_write(ra(1, OFF_COMPARE), 32'd2, 4'hF);
        bus_write(ra(1, OFF_CTRL), 32'd5, 4'hF);
        e0 = last_wr;
        wait_irq(1, 20, rise);
        check("t3_rise", 32'(rise - e0), 32'd3);
        bus_read(ra(1, OFF_CTRL), rd);  check("t3_ctrl1", rd, 32'd4);
        bus_read(ra(1, OFF_COUNT), rd); check("t3_count1", rd, 32'd2);
        bus_write(ADDR_STATUS, 32'h2, 4'hF);
        repeat (8) @(negedge clk);
        check("t3_no_refire", 32'(irq[1]), 32'h0);

        // ch2 wraps from max to 0 with no event, matches on the third tick.
        bus_write(ra(2, OFF_COUNT), 32'hFFFF_FFFF, 4'hF);
        bus_write(ra(2, OFF_COMPARE), 32'd1, 4'hF);
        bus_write(ra(2, OFF_PRESCALE), 32'd0, 4'hF);
        bus_write(ra(2, OFF_CTRL), 32'd7, 4'hF);
        e0 = last_wr;
        wait_irq(2, 20, rise);
        check("t4_rise", 32'(rise - e0), 32'd3);
        bus_write(ra(2, OFF_CTRL), 32'd0, 4'hF);
        bus_write(ADDR_STATUS, 32'hF, 4'hF);

        // COUNT write landing on a tick edge of ch3 (ticks every 2 clks).
        bus_write(ra(3, OFF_PRESCALE), 32'd1, 4'hF);
        bus_write(ra(3, OFF_COMPARE), 32'h100, 4'hF);
        bus_write(ra(3, OFF_CTRL), 32'd1, 4'hF);
        e0 = last_wr;
        wait_until(e0 + 3);
        bus_write(ra(3, OFF_COUNT), 32'h10, 4'hF);
        bus_read(ra(3, OFF_COUNT), rd); check("t5_count_write_wins", rd, 32'h10);
        bus_read(ra(3, OFF_COUNT), rd);
        bus_read(ra(3, OFF_COUNT), rd); check("t5_count_next_tick", rd, 32'h11);
        bus_write(ra(3, OFF_CTRL), 32'd0, 4'hF);

`ifdef TIMER_PWM_EN
        bus_write(ra(0, OFF_COUNT), 32'd0, 4'hF);
        bus_write(ra(0, OFF_COMPARE), 32'd4, 4'hF);
        bus_write(ra(0, OFF_PRESCALE), 32'd0, 4'hF);
        bus_write(ra(0, OFF_CTRL), 32'd3, 4'hF);
        repeat (6) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (pwm_out[0]) hi++;
        end
        check("t6_pwm_duty", 32'(hi), 32'd20);
        bus_write(ra(0, OFF_CTRL), 32'd0, 4'hF);
`endif

        // Randomized channel configurations against the closed-form model.
        for (int round = 0; round < 3; round++) begin
            pulse_reset();
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_p[ch]  = int'($urandom_range(0, 3));
                r_c[ch]  = int'($urandom_range(0, 6));
                r_c0[ch] = int'($urandom_range(0, r_c[ch]));
                r_rl[ch] = int'($urandom_range(0, 1));
                r_ie[ch] = int'($urandom_range(0, 1));
                r_e0[ch] = 1 << 30;
                bus_write(ra(ch, OFF_PRESCALE), 32'(r_p[ch]), 4'hF);
                bus_write(ra(ch, OFF_COMPARE), 32'(r_c[ch]), 4'hF);
                bus_write(ra(ch, OFF_COUNT), 32'(r_c0[ch]), 4'hF);
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                bus_write(ra(ch, OFF_CTRL), 32'(r_ie[ch] * 4 + r_rl[ch] * 2 + 1), 4'hF);
                r_e0[ch] = last_wr;
            end
            for (int it = 0; it < 60; it++) begin
                bus_read(ADDR_STATUS, rd);
                check("rnd_status", rd, 32'(exp_pending(cyc - 1)));
                ep = exp_pending(cyc) & ie_mask();
                check("rnd_irq", 32'(irq), 32'(ep));
                check("rnd_irq_any", 32'(irq_any), 32'(|ep));
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                bus_read(ra(ch, OFF_COUNT), rd);
                check("rnd_count", rd, exp_count(ch, cyc - 1));
                bus_read(ra(ch, OFF_CTRL), rd);
                check("rnd_ctrl", rd, exp_ctrl(ch, cyc - 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
